// File: rtl/aes_gcm_pkg.sv
// rtl/aes_gcm_pkg.sv - shared constants, state enum and helpers for the GCM block
package aes_gcm_pkg;

    localparam int BLK   = 128;
    localparam int CNT_W = 58;

    // GF(2^128) reduction constant: 0xE1 followed by 120 zero bits
    localparam logic [BLK-1:0] R_POLY = {8'hE1, 120'h0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_HKEY,
        S_J0,
        S_LEN,
        S_AAD,
        S_PT,
        S_FINAL,
        S_TAG
    } state_t;

    // number of 128-bit blocks covering len bits (partial block rounds up)
    function automatic logic [CNT_W-1:0] bit_len_to_blocks(input logic [63:0] len);
        return {1'b0, len[63:7]} + {{(CNT_W-1){1'b0}}, |len[6:0]};
    endfunction

endpackage

// File: rtl/aes_gcm_gf128_mul.sv
// rtl/aes_gcm_gf128_mul.sv - bit-serial GF(2^128) multiplier, one bit per cycle
module gf128_mul
    import aes_gcm_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [BLK-1:0] x,
    input  logic [BLK-1:0] h,
    output logic           done,
    output logic [BLK-1:0] z
);

    logic [BLK-1:0] xs;
    logic [BLK-1:0] v;
    logic [6:0]     cnt;
    logic           busy;

    // shift-and-add: consume x from bit 127 down, V walks through the field
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xs   <= '0;
            v    <= '0;
            z    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                xs   <= x;
                v    <= h;
                z    <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                if (xs[BLK-1]) begin
                    z <= z ^ v;
                end
                v   <= v[0] ? ((v >> 1) ^ R_POLY) : (v >> 1);
                xs  <= xs << 1;
                cnt <= cnt + 7'd1;
                if (cnt == 7'd127) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/aes_gcm.sv
// rtl/aes_gcm.sv - GCM encryption sequencer around an external AES engine
module aes_gcm
    import aes_gcm_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [BLK-1:0] iv,
    input  logic           iv_en,
    input  logic           key_expanded,
    output logic [BLK-1:0] aes_alg_in_blk,
    output logic           aes_alg_start,
    input  logic [BLK-1:0] aes_alg_out_blk,
    input  logic           aes_alg_done,
    input  logic [BLK-1:0] gcm_in_blk,
    input  logic           gcm_valid,
    output logic           gcm_ready,
    output logic [BLK-1:0] gcm_out_blk,
    output logic           gcm_op_done,
    output logic [BLK-1:0] gcm_tag,
    output logic           gcm_tag_done
);

    state_t           state;
    logic [95:0]      nonce;
    logic [BLK-1:0]   h_key;
    logic [BLK-1:0]   ej0;
    logic [BLK-1:0]   cb;
    logic [BLK-1:0]   acc;
    logic [BLK-1:0]   hdr;
    logic [BLK-1:0]   p_reg;
    logic [CNT_W-1:0] aad_cnt;
    logic [CNT_W-1:0] pt_cnt;
    logic             aes_wait;
    logic             mul_pend;
    logic             mul_start;
    logic [BLK-1:0]   mul_x;
    logic             mul_done;
    logic [BLK-1:0]   mul_z;

    logic             xfer;
    logic             aes_hit;
    logic [BLK-1:0]   cb_next;
    logic [BLK-1:0]   c_blk;
    logic [CNT_W-1:0] hdr_aad_n;
    logic [CNT_W-1:0] hdr_pt_n;

    assign gcm_ready = ((state == S_LEN) || (state == S_AAD) || (state == S_PT))
                       && !aes_wait && !mul_pend;
    assign xfer      = gcm_valid && gcm_ready;
    assign aes_hit   = aes_wait && aes_alg_done;
    assign cb_next   = {cb[127:32], cb[31:0] + 32'd1};
    assign c_blk     = p_reg ^ aes_alg_out_blk;
    assign hdr_aad_n = bit_len_to_blocks(gcm_in_blk[127:64]);
    assign hdr_pt_n  = bit_len_to_blocks(gcm_in_blk[63:0]);

    gf128_mul u_mul (
        .clk   (clk),
        .rst   (reset),
        .start (mul_start),
        .x     (mul_x),
        .h     (h_key),
        .done  (mul_done),
        .z     (mul_z)
    );

    // IV register: only the 96-bit nonce matters, sampled at operation start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nonce <= '0;
        end else if (iv_en) begin
            nonce <= iv[127:32];
        end
    end

    // operation sequencer: AES requests, GHASH feeding, ciphertext and tag outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            h_key          <= '0;
            ej0            <= '0;
            cb             <= '0;
            acc            <= '0;
            hdr            <= '0;
            p_reg          <= '0;
            aad_cnt        <= '0;
            pt_cnt         <= '0;
            aes_wait       <= 1'b0;
            mul_pend       <= 1'b0;
            mul_start      <= 1'b0;
            mul_x          <= '0;
            aes_alg_in_blk <= '0;
            aes_alg_start  <= 1'b0;
            gcm_out_blk    <= '0;
            gcm_op_done    <= 1'b0;
            gcm_tag        <= '0;
            gcm_tag_done   <= 1'b0;
        end else begin
            aes_alg_start <= 1'b0;
            gcm_op_done   <= 1'b0;
            gcm_tag_done  <= 1'b0;
            mul_start     <= 1'b0;
            case (state)
                S_IDLE: begin
                    acc <= '0;
                    if (key_expanded) begin
                        // J0 is fixed now so a later IV load only affects the next run
                        cb             <= {nonce, 32'h1};
                        aes_alg_in_blk <= '0;
                        aes_alg_start  <= 1'b1;
                        aes_wait       <= 1'b1;
                        state          <= S_HKEY;
                    end
                end
                S_HKEY: begin
                    if (aes_hit) begin
                        h_key          <= aes_alg_out_blk;
                        aes_alg_in_blk <= cb;
                        aes_alg_start  <= 1'b1;
                        state          <= S_J0;
                    end
                end
                S_J0: begin
                    if (aes_hit) begin
                        ej0      <= aes_alg_out_blk;
                        aes_wait <= 1'b0;
                        state    <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        hdr     <= gcm_in_blk;
                        aad_cnt <= hdr_aad_n;
                        pt_cnt  <= hdr_pt_n;
                        if (hdr_aad_n != '0) begin
                            state <= S_AAD;
                        end else if (hdr_pt_n != '0) begin
                            state <= S_PT;
                        end else begin
                            state <= S_FINAL;
                        end
                    end
                end
                S_AAD: begin
                    if (mul_done) begin
                        acc      <= mul_z;
                        mul_pend <= 1'b0;
                        aad_cnt  <= aad_cnt - 1'b1;
                        if (aad_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            state <= (pt_cnt != '0) ? S_PT : S_FINAL;
                        end
                    end else if (xfer) begin
                        mul_x     <= acc ^ gcm_in_blk;
                        mul_start <= 1'b1;
                        mul_pend  <= 1'b1;
                    end
                end
                S_PT: begin
                    if (mul_done) begin
                        acc      <= mul_z;
                        mul_pend <= 1'b0;
                        pt_cnt   <= pt_cnt - 1'b1;
                        if (pt_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            state <= S_FINAL;
                        end
                    end else if (aes_hit) begin
                        gcm_out_blk <= c_blk;
                        gcm_op_done <= 1'b1;
                        aes_wait    <= 1'b0;
                        mul_x       <= acc ^ c_blk;
                        mul_start   <= 1'b1;
                        mul_pend    <= 1'b1;
                    end else if (xfer) begin
                        p_reg          <= gcm_in_blk;
                        cb             <= cb_next;
                        aes_alg_in_blk <= cb_next;
                        aes_alg_start  <= 1'b1;
                        aes_wait       <= 1'b1;
                    end
                end
                S_FINAL: begin
                    if (mul_done) begin
                        acc      <= mul_z;
                        mul_pend <= 1'b0;
                        state    <= S_TAG;
                    end else if (!mul_pend) begin
                        mul_x     <= acc ^ hdr;
                        mul_start <= 1'b1;
                        mul_pend  <= 1'b1;
                    end
                end
                S_TAG: begin
                    gcm_tag      <= acc ^ ej0;
                    gcm_tag_done <= 1'b1;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_gcm.sv
// tb/tb_aes_gcm.sv - randomized self-checking bench for aes_gcm against a GCM reference model
module tb_aes_gcm;

    localparam logic [127:0] R_TB    = {8'hE1, 120'h0};
    localparam logic [127:0] IV_VEC  = 128'h3e894ebb16ce82a53c3e05b200000000;
    localparam logic [127:0] J0_VEC  = 128'h3e894ebb16ce82a53c3e05b200000001;
    localparam logic [127:0] CB2_VEC = 128'h3e894ebb16ce82a53c3e05b200000002;
    localparam logic [127:0] CB3_VEC = 128'h3e894ebb16ce82a53c3e05b200000003;
    localparam logic [127:0] H_VEC   = 128'hfe6225639b1a6e0c5d3b7a2f8e4c1d07;
    localparam logic [127:0] EJ0_VEC = 128'h69488eec1f2a3b4c5d6e7f8091a2b3c4;
    localparam logic [127:0] E2_VEC  = 128'h49b9736f9d82114b06a9ba85b6b5b4e4;
    localparam logic [127:0] E3_VEC  = 128'h71aa8c16a26a6a402b6876f24245301c;
    localparam logic [127:0] HDR_VEC = 128'h00000000000001800000000000000100;
    localparam logic [127:0] P1_VEC  = 128'hbb2bac67a4709430c39c2eb9acfabc0d;
    localparam logic [127:0] P2_VEC  = 128'h456c80d30aa1734e57997d548a8f0603;
    localparam logic [127:0] C1_VEC  = 128'hf292df0839f2857bc535943c1a4f08e9;
    localparam logic [127:0] C2_VEC  = 128'h34c60cc5a8cb190e7cf10ba6c8ca361f;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] iv = '0;
    logic         iv_en = 1'b0;
    logic         key_expanded = 1'b0;
    logic [127:0] aes_alg_in_blk;
    logic         aes_alg_start;
    logic [127:0] aes_alg_out_blk;
    logic         aes_alg_done;
    logic [127:0] gcm_in_blk = '0;
    logic         gcm_valid = 1'b0;
    logic         gcm_ready;
    logic [127:0] gcm_out_blk;
    logic         gcm_op_done;
    logic [127:0] gcm_tag;
    logic         gcm_tag_done;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    logic [127:0] c_q[$];
    logic [127:0] tag_q[$];
    logic [127:0] aes_log[$];
    logic [127:0] aad_d[8];
    logic [127:0] pt_d[8];
    logic [127:0] exp_c[8];
    logic [127:0] exp_tag;
    int           exp_na;
    int           exp_np;

    aes_gcm dut (
        .clk             (clk),
        .reset           (reset),
        .iv              (iv),
        .iv_en           (iv_en),
        .key_expanded    (key_expanded),
        .aes_alg_in_blk  (aes_alg_in_blk),
        .aes_alg_start   (aes_alg_start),
        .aes_alg_out_blk (aes_alg_out_blk),
        .aes_alg_done    (aes_alg_done),
        .gcm_in_blk      (gcm_in_blk),
        .gcm_valid       (gcm_valid),
        .gcm_ready       (gcm_ready),
        .gcm_out_blk     (gcm_out_blk),
        .gcm_op_done     (gcm_op_done),
        .gcm_tag         (gcm_tag),
        .gcm_tag_done    (gcm_tag_done)
    );

    always #5 clk = ~clk;

    // stand-in block cipher: fixed answers for the reference vector, a keyed mix otherwise
    function automatic logic [127:0] fake_aes(input logic [127:0] b);
        if (b == 128'h0)   return H_VEC;
        if (b == J0_VEC)   return EJ0_VEC;
        if (b == CB2_VEC)  return E2_VEC;
        if (b == CB3_VEC)  return E3_VEC;
        return {b[63:0], b[127:64]} ^ {4{32'h9e3779b9}} ^ (b << 7);
    endfunction

    // GF(2^128) product, bit 127 is the first (lowest-degree) coefficient
    function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z;
        logic [127:0] v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ R_TB) : (v >> 1);
        end
        return z;
    endfunction

    // whole-message GCM encryption of aad_d/pt_d under the given IV and header
    task automatic model_op(input logic [127:0] ivv, input logic [127:0] hdr);
        logic [127:0] hk, j0, cb, acc;
        longint la, lp;
        la = longint'(hdr[127:64]);
        lp = longint'(hdr[63:0]);
        exp_na = int'((la + 127) / 128);
        exp_np = int'((lp + 127) / 128);
        hk  = fake_aes('0);
        j0  = {ivv[127:32], 32'h1};
        acc = '0;
        for (int i = 0; i < exp_na; i++) acc = gf_mul(acc ^ aad_d[i], hk);
        cb = j0;
        for (int i = 0; i < exp_np; i++) begin
            cb[31:0] = cb[31:0] + 32'd1;
            exp_c[i] = pt_d[i] ^ fake_aes(cb);
            acc = gf_mul(acc ^ exp_c[i], hk);
        end
        acc = gf_mul(acc ^ hdr, hk);
        exp_tag = acc ^ fake_aes(j0);
    endtask

    // AES engine emulation with random latency
    initial begin
        logic [127:0] blk;
        aes_alg_done    = 1'b0;
        aes_alg_out_blk = '0;
        @(negedge clk);
        forever begin
            if (aes_alg_start === 1'b1 && reset === 1'b0) begin
                blk = aes_alg_in_blk;
                aes_log.push_back(blk);
                repeat ($urandom_range(1, 4)) @(negedge clk);
                if (reset === 1'b0) begin
                    checks++;
                    if (aes_alg_in_blk !== blk)
                        $display("FAIL aes_in_stable got %h want %h", aes_alg_in_blk, blk);
                    if (aes_alg_in_blk !== blk) errors++;
                end
                aes_alg_out_blk = fake_aes(blk);
                aes_alg_done    = 1'b1;
                @(negedge clk);
                aes_alg_done    = 1'b0;
                aes_alg_out_blk = {$urandom(), $urandom(), $urandom(), $urandom()};
            end else begin
                @(negedge clk);
            end
        end
    end

    // output pulse capture
    always @(negedge clk) begin
        if (gcm_op_done === 1'b1)  c_q.push_back(gcm_out_blk);
        if (gcm_tag_done === 1'b1) tag_q.push_back(gcm_tag);
    end

    always @(posedge clk) begin
        if (!reset && gcm_valid && gcm_ready) xfers++;
    end

    task automatic load_iv(input logic [127:0] v);
        @(negedge clk);
        iv    = v;
        iv_en = 1'b1;
        @(negedge clk);
        iv_en = 1'b0;
        iv    = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // drive one operation; abort_at >= 0 returns right after that block index transfers
    task automatic run_op(input logic [127:0] hdr, input bit hold, input int abort_at);
        logic [127:0] blk;
        int t;
        c_q.delete();
        tag_q.delete();
        aes_log.delete();
        xfers = 0;
        @(negedge clk);
        key_expanded = 1'b1;
        @(negedge clk);
        key_expanded = 1'b0;
        for (int i = 0; i < 1 + exp_na + exp_np; i++) begin
            blk = (i == 0) ? hdr : (i <= exp_na) ? aad_d[i-1] : pt_d[i-1-exp_na];
            gcm_in_blk = blk;
            gcm_valid  = 1'b1;
            t = 0;
            while (gcm_ready !== 1'b1 && t < 2000) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (t >= 2000) begin
                errors++;
                $display("FAIL ready_timeout block %0d got ready=%b want 1", i, gcm_ready);
            end
            @(negedge clk);
            if (i >= 1) begin
                checks++;
                if (gcm_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_after_xfer block %0d got %b want 0", i, gcm_ready);
                end
            end
            if (i == abort_at) return;
            if (!hold) begin
                gcm_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        gcm_valid = 1'b0;
        t = 0;
        while (tag_q.size() == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (tag_q.size() == 0) begin
            errors++;
            $display("FAIL tag_timeout got 0 tags want 1");
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 8; i++) begin
            aad_d[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt_d[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({gcm_ready, aes_alg_start, gcm_op_done, gcm_tag_done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000",
                     {gcm_ready, aes_alg_start, gcm_op_done, gcm_tag_done});
        end
        checks++;
        if (aes_alg_in_blk !== '0) begin
            errors++;
            $display("FAIL reset_aes_in got %h want 0", aes_alg_in_blk);
        end
        checks++;
        if (gcm_out_blk !== '0 || gcm_tag !== '0) begin
            errors++;
            $display("FAIL reset_data got out=%h tag=%h want 0", gcm_out_blk, gcm_tag);
        end
    endtask

    task automatic test_vector();
        logic [127:0] want_seq[4];
        want_seq = '{128'h0, J0_VEC, CB2_VEC, CB3_VEC};
        fill_random();
        pt_d[0] = P1_VEC;
        pt_d[1] = P2_VEC;
        load_iv(IV_VEC);
        model_op(IV_VEC, HDR_VEC);
        run_op(HDR_VEC, 1'b0, -1);
        checks++;
        if (aes_log.size() != 4) begin
            errors++;
            $display("FAIL vec_aes_count got %0d want 4", aes_log.size());
        end
        for (int i = 0; i < 4 && i < aes_log.size(); i++) begin
            checks++;
            if (aes_log[i] !== want_seq[i]) begin
                errors++;
                $display("FAIL vec_aes_in[%0d] got %h want %h", i, aes_log[i], want_seq[i]);
            end
        end
        checks++;
        if (c_q.size() != 2 || c_q[0] !== C1_VEC || c_q[1] !== C2_VEC) begin
            errors++;
            $display("FAIL vec_cipher got n=%0d c0=%h want %h,%h", c_q.size(),
                     (c_q.size() > 0) ? c_q[0] : 128'h0, C1_VEC, C2_VEC);
        end
        checks++;
        if (tag_q.size() != 1 || tag_q[0] !== exp_tag) begin
            errors++;
            $display("FAIL vec_tag got %h want %h", (tag_q.size() > 0) ? tag_q[0] : 128'h0, exp_tag);
        end
        checks++;
        if (xfers != 6) begin
            errors++;
            $display("FAIL vec_xfers got %0d want 6", xfers);
        end
        checks++;
        if (gcm_out_blk !== C2_VEC || gcm_tag !== exp_tag) begin
            errors++;
            $display("FAIL vec_hold got out=%h tag=%h want %h %h", gcm_out_blk, gcm_tag, C2_VEC, exp_tag);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] c0, c1, t0;
        model_op(IV_VEC, HDR_VEC);
        run_op(HDR_VEC, 1'b0, -1);
        c0 = (c_q.size() > 1) ? c_q[0] : '0;
        c1 = (c_q.size() > 1) ? c_q[1] : '0;
        t0 = (tag_q.size() > 0) ? tag_q[0] : '0;
        run_op(HDR_VEC, 1'b1, -1);
        checks++;
        if (c_q.size() != 2 || c_q[0] !== c0 || c_q[1] !== c1 || c0 !== C1_VEC || c1 !== C2_VEC) begin
            errors++;
            $display("FAIL b2b_cipher got n=%0d first=%h want %h", c_q.size(), c0, C1_VEC);
        end
        checks++;
        if (tag_q.size() != 1 || tag_q[0] !== t0 || t0 !== exp_tag) begin
            errors++;
            $display("FAIL b2b_tag got %h want %h", t0, exp_tag);
        end
    endtask

    task automatic test_random(input int runs, input bit force_hold);
        logic [127:0] v, hdr;
        for (int r = 0; r < runs; r++) begin
            fill_random();
            v   = {$urandom(), $urandom(), $urandom(), $urandom()};
            hdr = {32'h0, 32'($urandom_range(0, 384)), 32'h0, 32'($urandom_range(0, 384))};
            load_iv(v);
            model_op(v, hdr);
            run_op(hdr, force_hold | 1'($urandom_range(0, 1)), -1);
            checks++;
            if (c_q.size() != exp_np) begin
                errors++;
                $display("FAIL rand_op_count run %0d got %0d want %0d", r, c_q.size(), exp_np);
            end
            for (int i = 0; i < exp_np && i < c_q.size(); i++) begin
                checks++;
                if (c_q[i] !== exp_c[i]) begin
                    errors++;
                    $display("FAIL rand_cipher run %0d blk %0d got %h want %h", r, i, c_q[i], exp_c[i]);
                end
            end
            checks++;
            if (tag_q.size() != 1 || tag_q[0] !== exp_tag) begin
                errors++;
                $display("FAIL rand_tag run %0d got %h want %h", r,
                         (tag_q.size() > 0) ? tag_q[0] : 128'h0, exp_tag);
            end
            checks++;
            if (xfers != 1 + exp_na + exp_np) begin
                errors++;
                $display("FAIL rand_xfers run %0d got %0d want %0d", r, xfers, 1 + exp_na + exp_np);
            end
        end
    endtask

    task automatic test_empty();
        load_iv(IV_VEC);
        model_op(IV_VEC, 128'h0);
        run_op(128'h0, 1'b0, -1);
        checks++;
        if (tag_q.size() != 1 || tag_q[0] !== (gf_mul(128'h0, H_VEC) ^ EJ0_VEC)) begin
            errors++;
            $display("FAIL empty_tag got %h want %h", (tag_q.size() > 0) ? tag_q[0] : 128'h0, EJ0_VEC);
        end
        checks++;
        if (c_q.size() != 0) begin
            errors++;
            $display("FAIL empty_op_done got %0d pulses want 0", c_q.size());
        end
    endtask

    task automatic test_reset_mid();
        fill_random();
        load_iv(IV_VEC);
        model_op(IV_VEC, HDR_VEC);
        run_op(HDR_VEC, 1'b0, exp_na + 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        test_reset();
        c_q.delete();
        tag_q.delete();
        @(negedge clk);
        reset = 1'b0;
        gcm_valid = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (c_q.size() != 0 || tag_q.size() != 0 || aes_alg_start !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet got op=%0d tag=%0d want 0 0", c_q.size(), tag_q.size());
        end
        test_random(1, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_vector();
        test_back_to_back();
        test_random(2, 1'b1);
        test_empty();
        test_random(3, 1'b0);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_gcm.md
AES_GCM -- requirements
Module: aes_gcm

Interface
REQ-001 Parameters (fixed): BLK=128, all data, IV, H, tag and counter widths = 128 bits.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 iv  in  128  IV; bits[127:32] = 96-bit nonce, bits[31:0] ignored.
REQ-005 iv_en  in  1  load pulse for iv.
REQ-006 key_expanded  in  1  one-cycle pulse that starts a GCM operation (AES key ready).
REQ-007 aes_alg_in_blk  out  128  block to encrypt on the external AES engine.
REQ-008 aes_alg_start  out  1  one-cycle request to the AES engine.
REQ-009 aes_alg_out_blk  in  128  AES result, valid while aes_alg_done=1.
REQ-010 aes_alg_done  in  1  one-cycle AES completion pulse.
REQ-011 gcm_in_blk  in  128  input stream block (length header, AAD, plaintext).
REQ-012 gcm_valid / gcm_ready  in / out  1  handshake; a block transfers when both are 1 at a rising edge.
REQ-013 gcm_out_blk  out  128  ciphertext block.
REQ-014 gcm_op_done  out  1  one-cycle pulse marking gcm_out_blk valid.
REQ-015 gcm_tag  out  128  authentication tag.
REQ-016 gcm_tag_done  out  1  one-cycle pulse marking gcm_tag valid.

Function
REQ-017 Encryption only; H, J0, counter blocks and GHASH follow NIST SP 800-38D, GF(2^128) with R = 0xE1 followed by 120 zero bits, bit 127 = first bit.
REQ-018 An iv_en=1 edge registers iv; while busy, the new IV applies to the next operation only.
REQ-019 States: IDLE -> HKEY -> J0 -> LEN -> AAD -> PT -> FINAL -> TAG -> IDLE.
REQ-020 IDLE: wait for key_expanded; clear the GHASH accumulator.
REQ-021 HKEY: start AES with 0^128; on done, latch H.
REQ-022 J0: J0 = iv[127:32] concatenated with 32'h1; start AES(J0); on done, latch EJ0; set CB = J0.
REQ-023 LEN: gcm_ready=1; accept header {len(A)[63:0], len(P)[63:0]} in bits; latch it; AAD block count = ceil(len(A)/128); PT block count = ceil(len(P)/128).
REQ-024 AAD: for each accepted block X, acc = (acc xor X)*H; skip the state when the AAD count is 0.
REQ-025 PT: per block: accept P; CB low 32 bits += 1 (mod 2^32, upper 96 bits unchanged); start AES(CB); C = P xor result; gcm_out_blk = C with gcm_op_done pulse the cycle after aes_alg_done; acc = (acc xor C)*H; skip the state when the PT count is 0.
REQ-026 FINAL: acc = (acc xor header)*H; TAG: gcm_tag = acc xor EJ0, gcm_tag_done pulse one cycle, then IDLE.
REQ-027 gcm_ready=1 only in LEN, AAD and PT when no AES or multiply is in flight; gcm_valid is ignored otherwise.
REQ-028 aes_alg_start is a one-cycle pulse; aes_alg_in_blk is held stable until aes_alg_done.
REQ-029 aes_alg_done outside an AES wait is ignored.
REQ-030 Only whole 128-bit blocks are supported; partial final blocks are treated as full blocks, and the caller zero-pads them.
REQ-031 gcm_out_blk and gcm_tag hold their values until overwritten.
REQ-032 key_expanded outside IDLE is ignored.
REQ-033 GF multiply is bit-serial, 1 bit per cycle (128 cycles); no pipelining across blocks.

Reset
REQ-034 Reset forces: state IDLE; all outputs 0; iv, H, EJ0, CB, accumulator, header and counters cleared.
REQ-035 Reset mid-operation aborts the operation with no pulses emitted; a late aes_alg_done after reset is ignored.

Structure
REQ-036 Shared package holds the BLK width constant, the state enum and the R polynomial constant.
REQ-037 One sub-module, gf128_mul: start/done handshake, operands X and H, 128-cycle shift-and-add multiply.

Verification
REQ-038 Reset, then iv=3e894ebb16ce82a53c3e05b200000000 with key_expanded -> aes_alg_in_blk sequence is 0, ...05b200000001, ...05b200000002, ...05b200000003.
REQ-039 Header 00000000000001800000000000000100, 3 AAD blocks, 2 PT blocks (bb2bac67a4709430c39c2eb9acfabc0d, 456c80d30aa1734e57997d548a8f0603); AES model returns fe622563..., 69488eec..., 49b9736f9d82114b06a9ba85b6b5b4e4, 71aa8c16a26a6a402b6876f24245301c -> C = f292df0839f2857bc535943c1a4f08e9, 34c60cc5a8cb190e7cf10ba6c8ca361f; tag equals the SP 800-38D software model.
REQ-040 Run the same vectors twice back-to-back -> identical ciphertexts and tag; accumulator cleared between runs.
REQ-041 gcm_valid held high while a multiply is in progress -> gcm_ready=0 and no extra block is consumed.
REQ-042 Header with len(A)=0 and len(P)=0 -> tag = (header*H) xor EJ0; gcm_op_done never pulses.
REQ-043 Assert reset during PT -> all outputs 0 immediately; a new operation after reset completes correctly.
